multicycle_ctrl: RTL and testbench
==================================

Name: multicycle_ctrl

Overview:
- Main control FSM for the multicycle CPU datapath.
- Sequences fetch, decode, execute, memory and writeback over several cycles, waiting on a memory-ready handshake.
- Drives every datapath enable and mux select, plus the 3-bit aluop consumed by the ALU control decoder, which merges it with the instruction function field.
- Also keeps a retired-instruction counter and halt/illegal status.

Parameters:
- CNT_W, 16, width of retired-instruction counter (wraps modulo 2^CNT_W)

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  synchronous, active-high reset
- opcode  input  4  instruction opcode from IR, valid from DECODE onward
- zero  input  1  ALU zero flag
- mem_ready  input  1  memory completes the current access this cycle
- pc_write  output  1  PC load enable (includes resolved branch)
- pc_src  output  2  PC source: 00 ALU result, 01 ALUOut register, 10 jump target
- i_or_d  output  1  memory address select: 0 PC, 1 ALUOut
- mem_read  output  1  memory read request
- mem_write  output  1  memory write request
- ir_write  output  1  IR load enable
- reg_dst  output  1  destination register: 0 rt, 1 rd
- mem_to_reg  output  1  writeback source: 0 ALUOut, 1 MDR
- reg_write  output  1  register file write enable
- alu_src_a  output  1  ALU A operand: 0 PC, 1 register A
- alu_src_b  output  2  ALU B operand: 00 register B, 01 constant 4, 10 sign-extended immediate, 11 shifted immediate
- alu_op  output  3  aluop sent to the ALU control decoder
- halted  output  1  high while in HALT
- illegal_op  output  1  sticky; set by an undefined opcode
- state_o  output  4  current state, for debug
- retired  output  CNT_W  count of completed instructions

Behaviour:
- State register clocked on clk; reset has priority.
- While reset=1: next state FETCH, retired=0, illegal_op=0, and every output is forced to 0 combinationally.
- Reset mid-operation aborts any pending memory access without a write.
- States and encoding: FETCH=0, DECODE=1, MEM_ADDR=2, MEM_RD=3, MEM_WB=4, MEM_WR=5, R_EXEC=6, R_WB=7, I_EXEC=8, I_WB=9, BRANCH=10, JUMP=11, HALT=12. Encodings 13-15 go to FETCH.
- Outputs not listed for a state are 0.
- FETCH:
  - mem_read=1, i_or_d=0, alu_src_a=0, alu_src_b=01, alu_op=ADD, pc_src=00.
  - ir_write and pc_write are asserted only in a cycle with mem_ready=1; FETCH then moves to DECODE.
  - Otherwise FETCH holds, and the request stays asserted with no IR or PC update.
- DECODE:
  - alu_src_a=0, alu_src_b=11, alu_op=ADD (branch target into ALUOut).
  - Opcode latched internally into op_q.
  - Dispatch:
    - R-type (0000) -> R_EXEC
    - ADDI/ANDI/ORI/SLTI (0001-0100) -> I_EXEC
    - LW (0101) and SW (0110) -> MEM_ADDR
    - BEQ (0111) and BNE (1000) -> BRANCH
    - J (1001) -> JUMP
    - HALT (1111) -> HALT
    - any other opcode -> FETCH, sets illegal_op, retired not incremented.
- MEM_ADDR: alu_src_a=1, alu_src_b=10, alu_op=ADD. Goes to MEM_RD for LW, MEM_WR for SW.
- MEM_RD: mem_read=1, i_or_d=1. Holds until mem_ready=1, then -> MEM_WB.
- MEM_WB: reg_write=1, mem_to_reg=1, reg_dst=0. -> FETCH.
- MEM_WR: mem_write=1, i_or_d=1. Holds until mem_ready=1, then -> FETCH.
- R_EXEC: alu_src_a=1, alu_src_b=00, alu_op=RTYPE. -> R_WB.
- R_WB: reg_write=1, reg_dst=1, mem_to_reg=0. -> FETCH.
- I_EXEC: alu_src_a=1, alu_src_b=10, alu_op = ADD/AND/OR/SLT for ADDI/ANDI/ORI/SLTI respectively. -> I_WB.
- I_WB: reg_write=1, reg_dst=0, mem_to_reg=0. -> FETCH.
- BRANCH:
  - alu_src_a=1, alu_src_b=00, alu_op=SUB, pc_src=01.
  - pc_write = (BEQ & zero) | (BNE & ~zero).
  - -> FETCH.
- JUMP: pc_src=10, pc_write=1. -> FETCH.
- HALT: halted=1, all enables 0, absorbing; only reset exits.
- retired increments by 1 on the exit cycle of MEM_WB, MEM_WR (at mem_ready), R_WB, I_WB, BRANCH, JUMP, and on HALT entry. It wraps silently.
- Latency without memory stalls: R/I-type 4 cycles, LW 5, SW 4, branch 3, jump 3. Each cycle mem_ready stays low adds one cycle.

Decomposition:
- Package ctrl_pkg holds:
  - state encodings;
  - opcode constants;
  - aluop constants: ALUOP_RTYPE=3'b000, ALUOP_SUB=3'b001, ALUOP_ADD=3'b010, ALUOP_SLT=3'b011, ALUOP_AND=3'b100, ALUOP_OR=3'b101;
  - mux-select constants.
- One natural sub-module: ctrl_output_decode, a purely combinational state+op_q -> control-word mapping. It keeps the FSM next-state logic separate.

Test Plan:
- Reset held 2 cycles, then R-type opcode 0000 with mem_ready=1 -> states 0,1,6,7,0. R_EXEC alu_op=000. R_WB reg_write=1, reg_dst=1. retired=1.
- LW (0101) with mem_ready low 3 cycles in MEM_RD -> MEM_RD held 4 cycles with mem_read=1, i_or_d=1. MEM_WB mem_to_reg=1. Total 8 cycles. retired increments once.
- BEQ with zero=1 and then zero=0 -> pc_write=1 with pc_src=01 only in the first case. BNE gives the opposite result, alu_op=001 in both.
- ORI (0011) -> I_EXEC alu_op=101, alu_src_b=10. FETCH alu_op=010, alu_src_b=01.
- Opcode 1010 -> DECODE goes to FETCH, illegal_op=1 and stays 1, retired unchanged. HALT 1111 -> halted=1 and stays there for 10 cycles with all enables 0.
- Reset asserted mid-MEM_WR with mem_ready=0 -> mem_write=0 during reset, state_o=0 after reset, retired=0.

Source files
------------

// File: rtl/ctrl_pkg.sv
// Shared encodings for the multicycle CPU control path: states, opcodes,
// aluop codes, datapath mux selects and the packed control word.
package ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEM_ADDR = 4'd2,
    S_MEM_RD   = 4'd3,
    S_MEM_WB   = 4'd4,
    S_MEM_WR   = 4'd5,
    S_R_EXEC   = 4'd6,
    S_R_WB     = 4'd7,
    S_I_EXEC   = 4'd8,
    S_I_WB     = 4'd9,
    S_BRANCH   = 4'd10,
    S_JUMP     = 4'd11,
    S_HALT     = 4'd12
  } state_e;

  localparam logic [3:0] OP_RTYPE = 4'b0000;
  localparam logic [3:0] OP_ADDI  = 4'b0001;
  localparam logic [3:0] OP_ANDI  = 4'b0010;
  localparam logic [3:0] OP_ORI   = 4'b0011;
  localparam logic [3:0] OP_SLTI  = 4'b0100;
  localparam logic [3:0] OP_LW    = 4'b0101;
  localparam logic [3:0] OP_SW    = 4'b0110;
  localparam logic [3:0] OP_BEQ   = 4'b0111;
  localparam logic [3:0] OP_BNE   = 4'b1000;
  localparam logic [3:0] OP_J     = 4'b1001;
  localparam logic [3:0] OP_HALT  = 4'b1111;

  localparam logic [2:0] ALUOP_RTYPE = 3'b000;
  localparam logic [2:0] ALUOP_SUB   = 3'b001;
  localparam logic [2:0] ALUOP_ADD   = 3'b010;
  localparam logic [2:0] ALUOP_SLT   = 3'b011;
  localparam logic [2:0] ALUOP_AND   = 3'b100;
  localparam logic [2:0] ALUOP_OR    = 3'b101;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  localparam logic [1:0] ALUB_REG   = 2'b00;
  localparam logic [1:0] ALUB_FOUR  = 2'b01;
  localparam logic [1:0] ALUB_IMM   = 2'b10;
  localparam logic [1:0] ALUB_SHIMM = 2'b11;

  typedef struct packed {
    logic       pc_write;
    logic [1:0] pc_src;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [2:0] alu_op;
    logic       halted;
  } ctrl_t;

endpackage

// File: rtl/ctrl_output_decode.sv
// Purely combinational mapping from FSM state and latched opcode to the
// datapath control word.
module ctrl_output_decode
  import ctrl_pkg::*;
(
  input  state_e     state_i,
  input  logic [3:0] op_i,
  input  logic       zero_i,
  input  logic       mem_ready_i,
  output ctrl_t      ctrl_o
);

  always_comb begin
    ctrl_o = '0;
    case (state_i)
      S_FETCH: begin
        ctrl_o.mem_read  = 1'b1;
        ctrl_o.i_or_d    = 1'b0;
        ctrl_o.alu_src_a = 1'b0;
        ctrl_o.alu_src_b = ALUB_FOUR;
        ctrl_o.alu_op    = ALUOP_ADD;
        ctrl_o.pc_src    = PCSRC_ALU;
        ctrl_o.ir_write  = mem_ready_i;
        ctrl_o.pc_write  = mem_ready_i;
      end
      S_DECODE: begin
        ctrl_o.alu_src_a = 1'b0;
        ctrl_o.alu_src_b = ALUB_SHIMM;
        ctrl_o.alu_op    = ALUOP_ADD;
      end
      S_MEM_ADDR: begin
        ctrl_o.alu_src_a = 1'b1;
        ctrl_o.alu_src_b = ALUB_IMM;
        ctrl_o.alu_op    = ALUOP_ADD;
      end
      S_MEM_RD: begin
        ctrl_o.mem_read = 1'b1;
        ctrl_o.i_or_d   = 1'b1;
      end
      S_MEM_WB: begin
        ctrl_o.reg_write  = 1'b1;
        ctrl_o.mem_to_reg = 1'b1;
      end
      S_MEM_WR: begin
        ctrl_o.mem_write = 1'b1;
        ctrl_o.i_or_d    = 1'b1;
      end
      S_R_EXEC: begin
        ctrl_o.alu_src_a = 1'b1;
        ctrl_o.alu_src_b = ALUB_REG;
        ctrl_o.alu_op    = ALUOP_RTYPE;
      end
      S_R_WB: begin
        ctrl_o.reg_write = 1'b1;
        ctrl_o.reg_dst   = 1'b1;
      end
      S_I_EXEC: begin
        ctrl_o.alu_src_a = 1'b1;
        ctrl_o.alu_src_b = ALUB_IMM;
        case (op_i)
          OP_ANDI: ctrl_o.alu_op = ALUOP_AND;
          OP_ORI:  ctrl_o.alu_op = ALUOP_OR;
          OP_SLTI: ctrl_o.alu_op = ALUOP_SLT;
          default: ctrl_o.alu_op = ALUOP_ADD;
        endcase
      end
      S_I_WB: begin
        ctrl_o.reg_write = 1'b1;
      end
      S_BRANCH: begin
        ctrl_o.alu_src_a = 1'b1;
        ctrl_o.alu_src_b = ALUB_REG;
        ctrl_o.alu_op    = ALUOP_SUB;
        ctrl_o.pc_src    = PCSRC_ALUOUT;
        ctrl_o.pc_write  = ((op_i == OP_BEQ) && zero_i) || ((op_i == OP_BNE) && !zero_i);
      end
      S_JUMP: begin
        ctrl_o.pc_src   = PCSRC_JUMP;
        ctrl_o.pc_write = 1'b1;
      end
      S_HALT: begin
        ctrl_o.halted = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Main control FSM of the multicycle CPU: sequences instruction phases,
// drives datapath controls and tracks retired count and halt/illegal status.
module multicycle_ctrl
  import ctrl_pkg::*;
#(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [3:0]       opcode,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             pc_write,
  output logic [1:0]       pc_src,
  output logic             i_or_d,
  output logic             mem_read,
  output logic             mem_write,
  output logic             ir_write,
  output logic             reg_dst,
  output logic             mem_to_reg,
  output logic             reg_write,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [2:0]       alu_op,
  output logic             halted,
  output logic             illegal_op,
  output logic [3:0]       state_o,
  output logic [CNT_W-1:0] retired
);

  state_e           state_q, state_d;
  logic [3:0]       op_q;
  logic [CNT_W-1:0] retired_q;
  logic             illegal_q;
  logic             retire;
  logic             set_illegal;
  ctrl_t            ctrl;
  ctrl_t            ctrl_g;

  always_comb begin
    state_d     = state_q;
    retire      = 1'b0;
    set_illegal = 1'b0;
    case (state_q)
      S_FETCH:    if (mem_ready) state_d = S_DECODE;
      S_DECODE: begin
        case (opcode)
          OP_RTYPE:                           state_d = S_R_EXEC;
          OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI:  state_d = S_I_EXEC;
          OP_LW, OP_SW:                       state_d = S_MEM_ADDR;
          OP_BEQ, OP_BNE:                     state_d = S_BRANCH;
          OP_J:                               state_d = S_JUMP;
          OP_HALT: begin
            state_d = S_HALT;
            retire  = 1'b1;
          end
          default: begin
            state_d     = S_FETCH;
            set_illegal = 1'b1;
          end
        endcase
      end
      S_MEM_ADDR: state_d = (op_q == OP_SW) ? S_MEM_WR : S_MEM_RD;
      S_MEM_RD:   if (mem_ready) state_d = S_MEM_WB;
      S_MEM_WB: begin
        state_d = S_FETCH;
        retire  = 1'b1;
      end
      S_MEM_WR: begin
        if (mem_ready) begin
          state_d = S_FETCH;
          retire  = 1'b1;
        end
      end
      S_R_EXEC:   state_d = S_R_WB;
      S_I_EXEC:   state_d = S_I_WB;
      S_R_WB, S_I_WB, S_BRANCH, S_JUMP: begin
        state_d = S_FETCH;
        retire  = 1'b1;
      end
      S_HALT:     state_d = S_HALT;
      default:    state_d = S_FETCH;
    endcase
    if (reset) begin
      state_d     = S_FETCH;
      retire      = 1'b0;
      set_illegal = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_FETCH;
      op_q      <= '0;
      retired_q <= '0;
      illegal_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == S_DECODE) op_q <= opcode;
      if (retire) retired_q <= retired_q + CNT_W'(1);
      if (set_illegal) illegal_q <= 1'b1;
    end
  end

  ctrl_output_decode u_decode (
    .state_i     (state_q),
    .op_i        (op_q),
    .zero_i      (zero),
    .mem_ready_i (mem_ready),
    .ctrl_o      (ctrl)
  );

  // Reset masks every output combinationally so an in-flight access is dropped at once.
  assign ctrl_g = reset ? '0 : ctrl;

  assign pc_write   = ctrl_g.pc_write;
  assign pc_src     = ctrl_g.pc_src;
  assign i_or_d     = ctrl_g.i_or_d;
  assign mem_read   = ctrl_g.mem_read;
  assign mem_write  = ctrl_g.mem_write;
  assign ir_write   = ctrl_g.ir_write;
  assign reg_dst    = ctrl_g.reg_dst;
  assign mem_to_reg = ctrl_g.mem_to_reg;
  assign reg_write  = ctrl_g.reg_write;
  assign alu_src_a  = ctrl_g.alu_src_a;
  assign alu_src_b  = ctrl_g.alu_src_b;
  assign alu_op     = ctrl_g.alu_op;
  assign halted     = ctrl_g.halted;
  assign illegal_op = reset ? 1'b0 : illegal_q;
  assign state_o    = reset ? 4'd0 : state_q;
  assign retired    = reset ? '0 : retired_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Scoreboard bench for multicycle_ctrl: each driven cycle queues its expected
// outputs, and a negedge monitor pops and compares them.
module tb_multicycle_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  opcode;
  logic        zero;
  logic        mem_ready;
  logic        pc_write, i_or_d, mem_read, mem_write, ir_write;
  logic        reg_dst, mem_to_reg, reg_write, alu_src_a, halted, illegal_op;
  logic [1:0]  pc_src, alu_src_b;
  logic [2:0]  alu_op;
  logic [3:0]  state_o;
  logic [15:0] retired;

  multicycle_ctrl #(.CNT_W(16)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
    .pc_write(pc_write), .pc_src(pc_src), .i_or_d(i_or_d), .mem_read(mem_read),
    .mem_write(mem_write), .ir_write(ir_write), .reg_dst(reg_dst),
    .mem_to_reg(mem_to_reg), .reg_write(reg_write), .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b), .alu_op(alu_op), .halted(halted),
    .illegal_op(illegal_op), .state_o(state_o), .retired(retired)
  );

  always #5 clk = ~clk;

  localparam logic [2:0] A_RT = 3'b000, A_SUB = 3'b001, A_ADD = 3'b010,
                         A_SLT = 3'b011, A_AND = 3'b100, A_OR = 3'b101;

  typedef struct {
    logic [3:0]  st;
    logic [15:0] cw;
    logic [15:0] ret;
    logic        ill;
    logic        hlt;
  } ent_t;

  ent_t        sb[$];
  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;
  int unsigned cyc_no   = 0;
  logic [3:0]  cur_op   = 4'd0;
  logic [15:0] exp_ret  = '0;
  logic        exp_ill  = 1'b0;
  logic        exp_hlt  = 1'b0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  function automatic logic [15:0] cw(input logic pcw, input logic [1:0] pcs, input logic iord,
                                     input logic mr, input logic mw, input logic irw,
                                     input logic rd, input logic m2r, input logic rw,
                                     input logic asa, input logic [1:0] asb,
                                     input logic [2:0] aop);
    return {pcw, pcs, iord, mr, mw, irw, rd, m2r, rw, asa, asb, aop};
  endfunction

  task automatic cyc(input logic rst, input logic rdy, input logic z,
                     input logic [3:0] st, input logic [15:0] c);
    ent_t e;
    @(posedge clk);
    #1;
    reset     = rst;
    mem_ready = rdy;
    zero      = z;
    opcode    = cur_op;
    e.st  = st;
    e.cw  = c;
    e.ret = exp_ret;
    e.ill = exp_ill;
    e.hlt = exp_hlt;
    sb.push_back(e);
  endtask

  task automatic rst_cyc();
    exp_ret = '0;
    exp_ill = 1'b0;
    exp_hlt = 1'b0;
    cyc(1'b1, 1'b0, 1'b0, 4'd0, 16'd0);
  endtask

  task automatic instr(input logic [3:0] op, input int unsigned fst, input int unsigned mst,
                       input logic z);
    logic [2:0] aop;
    logic       tk;
    cur_op = op;
    repeat (fst) cyc(0, 0, 0, 4'd0, cw(0, 2'b00, 0, 1, 0, 0, 0, 0, 0, 0, 2'b01, A_ADD));
    cyc(0, 1, 0, 4'd0, cw(1, 2'b00, 0, 1, 0, 1, 0, 0, 0, 0, 2'b01, A_ADD));
    cyc(0, 0, 0, 4'd1, cw(0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 2'b11, A_ADD));
    case (op)
      4'b0000: begin
        cyc(0, 0, 0, 4'd6, cw(0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 1, 2'b00, A_RT));
        cyc(0, 0, 0, 4'd7, cw(0, 2'b00, 0, 0, 0, 0, 1, 0, 1, 0, 2'b00, 3'd0));
        exp_ret++;
      end
      4'b0001, 4'b0010, 4'b0011, 4'b0100: begin
        aop = (op == 4'b0001) ? A_ADD : (op == 4'b0010) ? A_AND : (op == 4'b0011) ? A_OR : A_SLT;
        cyc(0, 0, 0, 4'd8, cw(0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 1, 2'b10, aop));
        cyc(0, 0, 0, 4'd9, cw(0, 2'b00, 0, 0, 0, 0, 0, 0, 1, 0, 2'b00, 3'd0));
        exp_ret++;
      end
      4'b0101: begin
        cyc(0, 0, 0, 4'd2, cw(0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 1, 2'b10, A_ADD));
        repeat (mst) cyc(0, 0, 0, 4'd3, cw(0, 2'b00, 1, 1, 0, 0, 0, 0, 0, 0, 2'b00, 3'd0));
        cyc(0, 1, 0, 4'd3, cw(0, 2'b00, 1, 1, 0, 0, 0, 0, 0, 0, 2'b00, 3'd0));
        cyc(0, 0, 0, 4'd4, cw(0, 2'b00, 0, 0, 0, 0, 0, 1, 1, 0, 2'b00, 3'd0));
        exp_ret++;
      end
      4'b0110: begin
        cyc(0, 0, 0, 4'd2, cw(0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 1, 2'b10, A_ADD));
        repeat (mst) cyc(0, 0, 0, 4'd5, cw(0, 2'b00, 1, 0, 1, 0, 0, 0, 0, 0, 2'b00, 3'd0));
        cyc(0, 1, 0, 4'd5, cw(0, 2'b00, 1, 0, 1, 0, 0, 0, 0, 0, 2'b00, 3'd0));
        exp_ret++;
      end
      4'b0111, 4'b1000: begin
        tk = (op == 4'b0111) ? z : ~z;
        cyc(0, 0, z, 4'd10, cw(tk, 2'b01, 0, 0, 0, 0, 0, 0, 0, 1, 2'b00, A_SUB));
        exp_ret++;
      end
      4'b1001: begin
        cyc(0, 0, 0, 4'd11, cw(1, 2'b10, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 3'd0));
        exp_ret++;
      end
      4'b1111: begin
        exp_ret++;
        exp_hlt = 1'b1;
      end
      default: exp_ill = 1'b1;
    endcase
  endtask

  always @(negedge clk) begin
    ent_t e;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      cyc_no++;
      check_eq($sformatf("state@%0d", cyc_no), {28'd0, state_o}, {28'd0, e.st});
      check_eq($sformatf("ctl@%0d", cyc_no),
               {16'd0, pc_write, pc_src, i_or_d, mem_read, mem_write, ir_write, reg_dst,
                mem_to_reg, reg_write, alu_src_a, alu_src_b, alu_op}, {16'd0, e.cw});
      check_eq($sformatf("retired@%0d", cyc_no), {16'd0, retired}, {16'd0, e.ret});
      check_eq($sformatf("illegal@%0d", cyc_no), {31'd0, illegal_op}, {31'd0, e.ill});
      check_eq($sformatf("halted@%0d", cyc_no), {31'd0, halted}, {31'd0, e.hlt});
    end
  end

  initial begin
    reset = 1'b1; opcode = 4'd0; zero = 1'b0; mem_ready = 1'b0;
    rst_cyc();
    rst_cyc();
    instr(4'b0000, 0, 0, 0);
    instr(4'b0101, 0, 3, 0);
    instr(4'b0110, 1, 1, 0);
    instr(4'b0111, 0, 0, 1);
    instr(4'b0111, 0, 0, 0);
    instr(4'b1000, 0, 0, 1);
    instr(4'b1000, 2, 0, 0);
    instr(4'b0011, 0, 0, 0);
    instr(4'b0001, 0, 0, 0);
    instr(4'b0010, 0, 0, 0);
    instr(4'b0100, 0, 0, 0);
    instr(4'b1001, 0, 0, 0);
    instr(4'b1010, 0, 0, 0);
    instr(4'b0000, 0, 0, 0);
    instr(4'b1111, 0, 0, 0);
    for (int i = 0; i < 10; i++)
      cyc(0, 1'($urandom_range(1)), 1'($urandom_range(1)), 4'd12, 16'd0);
    rst_cyc();
    cur_op = 4'b0110;
    cyc(0, 1, 0, 4'd0, cw(1, 2'b00, 0, 1, 0, 1, 0, 0, 0, 0, 2'b01, A_ADD));
    cyc(0, 0, 0, 4'd1, cw(0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 2'b11, A_ADD));
    cyc(0, 0, 0, 4'd2, cw(0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 1, 2'b10, A_ADD));
    cyc(0, 0, 0, 4'd5, cw(0, 2'b00, 1, 0, 1, 0, 0, 0, 0, 0, 2'b00, 3'd0));
    cyc(0, 0, 0, 4'd5, cw(0, 2'b00, 1, 0, 1, 0, 0, 0, 0, 0, 2'b00, 3'd0));
    rst_cyc();
    instr(4'b0000, 0, 0, 0);
    @(posedge clk);
    @(negedge clk);
    @(negedge clk);
    check_eq("sb_drain", sb.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
